// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and FSM encodings for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned WORD   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        WBA_RUN   = 2'd0,
        WBA_DRAIN = 2'd1,
        WBA_DONE  = 2'd2
    } wba_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Long-latency result queue with per-entry valid bits, WAW kill by rd and a source-check port.
module wb_result_fifo #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill,
    input  logic [REG_AW-1:0] kill_rd,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              chk_pending,
    output logic              head_valid,
    output logic [REG_AW-1:0] head_rd,
    output logic [WORD_W-1:0] head_data,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [WORD_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Valid bits are only ever set for occupied slots, so kill/check can scan every slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (rd_mem[i] == kill_rd) vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        chk_pending = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld[i] && (rd_mem[i] == chk_rd)) chk_pending = 1'b1;
        end
        if (chk_rd == '0) chk_pending = 1'b0;
    end

    assign head_valid = vld[rd_ptr];
    assign head_rd    = rd_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back and queued long-latency results,
// throttles a starving queue and sequences termination so no queued result is lost.
module wb_port_arbiter #(
    parameter int unsigned WORD_W     = wb_port_arbiter_pkg::WORD,
    parameter int unsigned REG_AW     = wb_port_arbiter_pkg::REG_AW,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [WORD_W-1:0] pipe_data,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_rd,
    input  logic [WORD_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic              lu_busy,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              chk_pending,
    input  logic              terminate,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [WORD_W-1:0] rf_wdata,
    output logic              pipe_stall,
    output logic              done
);

    import wb_port_arbiter_pkg::*;

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    wba_state_e          state, state_nxt;
    logic [STARVE_W-1:0] starve_cnt, starve_nxt;
    logic                stall_nxt;
    logic                push, pop, kill, blocked;
    logic                wr_en;
    logic [REG_AW-1:0]   wr_addr;
    logic [WORD_W-1:0]   wr_data;
    logic                head_valid, empty, full;
    logic [REG_AW-1:0]   head_rd;
    logic [WORD_W-1:0]   head_data;

    wb_result_fifo #(
        .WORD_W (WORD_W),
        .REG_AW (REG_AW),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_rd     (lu_rd),
        .push_data   (lu_data),
        .pop         (pop),
        .kill        (kill),
        .kill_rd     (pipe_rd),
        .chk_rd      (chk_rd),
        .chk_pending (chk_pending),
        .head_valid  (head_valid),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .empty       (empty),
        .full        (full)
    );

    // Not pop-aware: a full queue refuses even when it drains this cycle.
    assign lu_ready = !full && (state != WBA_DONE);
    assign push     = lu_valid && lu_ready && (lu_rd != '0);
    assign blocked  = (state == WBA_RUN) && pipe_we && !empty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        kill      = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = pipe_rd;
        wr_data   = pipe_data;
        case (state)
            WBA_RUN: begin
                if (pipe_we) begin
                    kill  = 1'b1;
                    wr_en = (pipe_rd != '0);
                end else if (!empty) begin
                    pop     = 1'b1;
                    wr_en   = head_valid;
                    wr_addr = head_rd;
                    wr_data = head_data;
                end
                if (terminate) state_nxt = WBA_DRAIN;
            end
            WBA_DRAIN: begin
                if (!empty) begin
                    pop     = 1'b1;
                    wr_en   = head_valid;
                    wr_addr = head_rd;
                    wr_data = head_data;
                end else if (!lu_busy && !lu_valid) begin
                    state_nxt = WBA_DONE;
                end
            end
            WBA_DONE:  state_nxt = WBA_DONE;
            default:   state_nxt = WBA_RUN;
        endcase
    end

    // Starvation: count consecutive blocked cycles; stall holds until the next pop.
    always_comb begin
        starve_nxt = starve_cnt;
        stall_nxt  = pipe_stall;
        if (pop) begin
            starve_nxt = '0;
            stall_nxt  = 1'b0;
        end else if (empty) begin
            starve_nxt = '0;
        end else if (blocked) begin
            if (starve_cnt == STARVE_W'(STARVE_MAX)) stall_nxt = 1'b1;
            else                                     starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WBA_RUN;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            pipe_stall <= stall_nxt;
            rf_we      <= wr_en;
            if (wr_en) begin
                rf_waddr <= wr_addr;
                rf_wdata <= wr_data;
            end
            done       <= (state_nxt == WBA_DONE);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model plus directed scenarios.
module tb_wb_port_arbiter;

    localparam int unsigned WW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned SMAX  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_we;
    logic [AW-1:0] pipe_rd;
    logic [WW-1:0] pipe_data;
    logic          lu_valid;
    logic [AW-1:0] lu_rd;
    logic [WW-1:0] lu_data;
    logic          lu_ready;
    logic          lu_busy;
    logic [AW-1:0] chk_rd;
    logic          chk_pending;
    logic          terminate;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [WW-1:0] rf_wdata;
    logic          pipe_stall;
    logic          done;

    wb_port_arbiter #(
        .WORD_W     (WW),
        .REG_AW     (AW),
        .BUF_DEPTH  (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_we     (pipe_we),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .lu_busy     (lu_busy),
        .chk_rd      (chk_rd),
        .chk_pending (chk_pending),
        .terminate   (terminate),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pipe_stall  (pipe_stall),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [WW-1:0] data;
        bit            live;
    } ent_t;

    // Reference model: queue of outstanding results and a phase (0 run, 1 drain, 2 done).
    ent_t          q[$];
    int            phase;
    int            run_len;
    bit            m_stall;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [WW-1:0] exp_data;
    int            vectors = 0;
    int            errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        phase   = 0;
        run_len = 0;
        m_stall = 0;
        exp_we  = 0;
    endtask

    task automatic set_in(input bit we, input int prd, input int pdat, input bit lv, input int lrd,
                          input int ldat, input bit busy, input int crd, input bit term);
        pipe_we   = we;
        pipe_rd   = AW'(prd);
        pipe_data = WW'(pdat);
        lu_valid  = lv;
        lu_rd     = AW'(lrd);
        lu_data   = WW'(ldat);
        lu_busy   = busy;
        chk_rd    = AW'(crd);
        terminate = term;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit   ready, pend, popped, blocked, was_empty;
        ent_t h;
        ent_t e;
        #2;
        ready = (q.size() < DEPTH) && (phase != 2);
        pend  = 0;
        foreach (q[i]) if (q[i].live && q[i].rd == chk_rd && chk_rd != 0) pend = 1;
        chk("lu_ready", 64'(lu_ready), 64'(ready));
        chk("chk_pending", 64'(chk_pending), 64'(pend));
        was_empty = (q.size() == 0);
        popped    = 0;
        blocked   = 0;
        exp_we    = 0;
        if (phase == 0) begin
            if (pipe_we) begin
                if (pipe_rd != 0) begin
                    exp_we = 1; exp_addr = pipe_rd; exp_data = pipe_data;
                end
                foreach (q[i]) if (q[i].rd == pipe_rd) q[i].live = 0;
                blocked = !was_empty;
            end else if (!was_empty) begin
                h = q.pop_front(); popped = 1;
                if (h.live) begin exp_we = 1; exp_addr = h.rd; exp_data = h.data; end
            end
            if (terminate) phase = 1;
        end else if (phase == 1) begin
            if (!was_empty) begin
                h = q.pop_front(); popped = 1;
                if (h.live) begin exp_we = 1; exp_addr = h.rd; exp_data = h.data; end
            end else if (!lu_busy && !lu_valid) begin
                phase = 2;
            end
        end
        if (popped) begin
            run_len = 0; m_stall = 0;
        end else if (was_empty) begin
            run_len = 0;
        end else if (blocked) begin
            if (run_len >= int'(SMAX)) m_stall = 1;
            run_len++;
        end
        if (lu_valid && ready && lu_rd != 0) begin
            e.rd = lu_rd; e.data = lu_data; e.live = 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("rf_we", 64'(rf_we), 64'(exp_we));
        if (exp_we) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(exp_addr));
            chk("rf_wdata", 64'(rf_wdata), 64'(exp_data));
        end
        chk("pipe_stall", 64'(pipe_stall), 64'(m_stall));
        chk("done", 64'(done), 64'(phase == 2));
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(pipe_stall), 64'd0);
        chk("rst_lu_ready", 64'(lu_ready), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Pipeline write, then a write to r0 that must be suppressed.
        set_in(1, 3, 'h11, 0, 0, 0, 0, 0, 0); step();
        chk("pipe_wr_we", 64'(rf_we), 64'd1);
        chk("pipe_wr_addr", 64'(rf_waddr), 64'd3);
        chk("pipe_wr_data", 64'(rf_wdata), 64'h11);
        set_in(1, 0, 'h22, 0, 0, 0, 0, 0, 0); step();
        chk("pipe_r0_we", 64'(rf_we), 64'd0);

        // LU result into an idle slot, visible as pending in between.
        set_in(0, 0, 0, 1, 5, 'hAA, 0, 5, 0); #1;
        chk("lu_acc_ready", 64'(lu_ready), 64'd1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 5, 0); #1;
        chk("lu_pending", 64'(chk_pending), 64'd1);
        step();
        chk("lu_wr_we", 64'(rf_we), 64'd1);
        chk("lu_wr_addr", 64'(rf_waddr), 64'd5);
        chk("lu_wr_data", 64'(rf_wdata), 64'hAA);

        // Starvation: fill the queue while the pipeline keeps writing.
        set_in(1, 1, 1, 1, 9, 'h99, 0, 0, 0); step();
        set_in(1, 1, 1, 1, 10, 'hA0, 0, 0, 0); step();
        for (int i = 0; i < int'(SMAX); i++) begin
            set_in(1, 1, 1, 1, 11, 'hB0, 0, 0, 0); step();
        end
        chk("stall_set", 64'(pipe_stall), 64'd1);
        set_in(0, 0, 0, 1, 11, 'hB0, 0, 0, 0); #1;
        chk("full_ready", 64'(lu_ready), 64'd0);
        step();
        chk("stall_pop_addr", 64'(rf_waddr), 64'd9);
        chk("stall_clear", 64'(pipe_stall), 64'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // WAW: younger pipeline write kills the queued entry for the same register.
        set_in(0, 0, 0, 1, 7, 1, 0, 7, 0); step();
        set_in(1, 7, 2, 0, 0, 0, 0, 7, 0); step();
        chk("waw_data", 64'(rf_wdata), 64'd2);
        set_in(0, 0, 0, 0, 0, 0, 0, 7, 0); step();
        chk("waw_stale_we", 64'(rf_we), 64'd0);

        // Termination with two queued results and a late LU result.
        set_in(1, 1, 1, 1, 12, 'hC, 0, 0, 0); step();
        set_in(1, 1, 1, 1, 13, 'hD, 0, 0, 0); step();
        set_in(1, 2, 'h22, 0, 0, 0, 1, 0, 1); step();
        chk("term_pipe_addr", 64'(rf_waddr), 64'd2);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4, 4, 0, 0, 0, 1, 0, 0); step();
        end
        set_in(0, 0, 0, 1, 14, 'hE, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("drain_lu_addr", 64'(rf_waddr), 64'd14);
        chk("drain_lu_data", 64'(rf_wdata), 64'hE);
        step();
        chk("done_set", 64'(done), 64'd1);
        set_in(1, 3, 3, 0, 0, 0, 0, 0, 0); step();
        chk("done_no_write", 64'(rf_we), 64'd0);

        // Reset while draining discards the queue.
        do_reset();
        set_in(1, 1, 5, 1, 20, 'h20, 0, 0, 0); step();
        set_in(1, 1, 5, 1, 21, 'h21, 0, 0, 0); step();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("drain_pop_we", 64'(rf_we), 64'd1);
        do_reset();
        for (int i = 0; i < 4; i++) step();

        // Randomised episodes, each ending in termination and drain.
        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                set_in(!m_stall && ($urandom_range(2) != 0), $urandom_range(7), $urandom,
                       $urandom_range(1), $urandom_range(7), $urandom, $urandom_range(1),
                       $urandom_range(7), (c >= 40) && ($urandom_range(7) == 0));
                step();
            end
            for (int c = 0; c < 20; c++) begin
                set_in(!m_stall && ($urandom_range(1) != 0), $urandom_range(7), $urandom,
                       (c < 5) && ($urandom_range(1) != 0), $urandom_range(7), $urandom,
                       (c < 5) && ($urandom_range(1) != 0), $urandom_range(7), c == 0);
                step();
            end
            chk("episode_done", 64'(done), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
